// File: rtl/regfile16_onehot_wr.sv
// 16x WIDTH register file, one-hot write select, two registered write-first read ports.
// Optional: REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile16_onehot_wr #(
    parameter int WIDTH = 8,
    parameter int ERRW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [15:0]      wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       ra_addr,
    input  logic [3:0]       rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             wr_done,
    output logic             sel_err,
    output logic [ERRW-1:0]  err_cnt
);

    logic [WIDTH-1:0] mem [16];
    logic [4:0]       ones;
    logic [3:0]       widx;
    logic             wvalid;
    logic             wbad;
    logic             wstore;
    logic [WIDTH-1:0] ra_nxt;
    logic [WIDTH-1:0] rb_nxt;

    always_comb begin
        ones = '0;
        widx = '0;
        for (int i = 0; i < 16; i++) begin
            if (wsel[i]) begin
                ones = ones + 5'd1;
                widx = 4'(i);
            end
        end
    end

    assign wvalid = we && (ones == 5'd1);
    assign wbad   = we && (ones != 5'd1);

`ifdef REGFILE_R0_ZERO_EN
    assign wstore = wvalid && (widx != 4'd0);
`else
    assign wstore = wvalid;
`endif

    // Read mux with write-first bypass; only a stored write may forward.
    always_comb begin
        ra_nxt = mem[ra_addr];
        rb_nxt = mem[rb_addr];
        if (wstore && (widx == ra_addr)) begin
            ra_nxt = wdata;
        end
        if (wstore && (widx == rb_addr)) begin
            rb_nxt = wdata;
        end
`ifdef REGFILE_R0_ZERO_EN
        if (ra_addr == 4'd0) begin
            ra_nxt = '0;
        end
        if (rb_addr == 4'd0) begin
            rb_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (wstore) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_data <= '0;
            rb_data <= '0;
            wr_done <= 1'b0;
        end else begin
            ra_data <= ra_nxt;
            rb_data <= rb_nxt;
            wr_done <= wvalid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (wbad) begin
            sel_err <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERRW'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile16_onehot_wr.sv
// Randomised and directed bench for regfile16_onehot_wr against an array model.
// Honours REGFILE_R0_ZERO_EN when defined for the build.
module tb_regfile16_onehot_wr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [15:0] wsel;
    logic [7:0]  wdata;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [7:0]  ra_data;
    logic [7:0]  rb_data;
    logic        wr_done;
    logic        sel_err;
    logic [3:0]  err_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_reg [16];
    logic [7:0] e_ra, e_rb;
    logic       e_done, e_err;
    int         e_cnt;

    regfile16_onehot_wr #(.WIDTH(8), .ERRW(4)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
        .rb_data(rb_data), .wr_done(wr_done), .sel_err(sel_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ra_data"}, int'(ra_data), int'(e_ra));
        chk({tag, ".rb_data"}, int'(rb_data), int'(e_rb));
        chk({tag, ".wr_done"}, int'(wr_done), int'(e_done));
        chk({tag, ".sel_err"}, int'(sel_err), int'(e_err));
        chk({tag, ".err_cnt"}, int'(err_cnt), e_cnt);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_reg[k] = 8'h00;
        e_ra = 0; e_rb = 0; e_done = 0; e_err = 0; e_cnt = 0;
    endtask

    function automatic logic [7:0] rd(input int a, input logic v, input int wi,
                                      input logic [7:0] d);
        logic [7:0] r;
        r = (v && wi == a) ? d : m_reg[a];
`ifdef REGFILE_R0_ZERO_EN
        if (a == 0) r = 8'h00;
`endif
        return r;
    endfunction

    // Apply one cycle of inputs at a falling edge, then check at the next one.
    task automatic cyc(input logic w, input logic [15:0] s, input logic [7:0] d,
                       input logic [3:0] a, input logic [3:0] b, input string tag);
        int   wi;
        logic v;
        we = w; wsel = s; wdata = d; ra_addr = a; rb_addr = b;
        wi = 0;
        for (int k = 0; k < 16; k++) if (s[k]) wi = k;
        v = w && ($countones(s) == 1);
        e_ra = rd(int'(a), v, wi, d);
        e_rb = rd(int'(b), v, wi, d);
        e_done = v;
        if (v) m_reg[wi] = d;
`ifdef REGFILE_R0_ZERO_EN
        m_reg[0] = 8'h00;
`endif
        if (w && !v) begin
            e_err = 1'b1;
            e_cnt = (e_cnt < 15) ? e_cnt + 1 : 15;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] s;
        rst_n = 1'b0;
        we = 0; wsel = 0; wdata = 0; ra_addr = 0; rb_addr = 0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all("in_reset");
        end
        rst_n = 1'b1;

        cyc(0, 16'h0000, 8'h00, 4'd5, 4'd15, "rst_read");
        chk("rst_read.ra_lit", int'(ra_data), 0);
        chk("rst_read.rb_lit", int'(rb_data), 0);

        cyc(1, 16'h0008, 8'hA5, 4'd0, 4'd0, "wr3");
        chk("wr3.done_lit", int'(wr_done), 1);
        cyc(0, 16'h0000, 8'h00, 4'd3, 4'd2, "rd3");
        chk("rd3.ra_lit", int'(ra_data), 8'hA5);
        chk("rd3.rb_lit", int'(rb_data), 8'h00);
        chk("rd3.done_lit", int'(wr_done), 0);

        cyc(1, 16'h0080, 8'h11, 4'd0, 4'd0, "wr7");
        cyc(1, 16'h0080, 8'h3C, 4'd7, 4'd7, "fwd7");
        chk("fwd7.ra_lit", int'(ra_data), 8'h3C);
        chk("fwd7.rb_lit", int'(rb_data), 8'h3C);

        cyc(1, 16'h0001, 8'h77, 4'd0, 4'd0, "r0wr");
        chk("r0wr.done_lit", int'(wr_done), 1);
        cyc(0, 16'h0000, 8'h00, 4'd0, 4'd0, "r0rd");
`ifdef REGFILE_R0_ZERO_EN
        chk("r0rd.ra_lit", int'(ra_data), 8'h00);
`else
        chk("r0rd.ra_lit", int'(ra_data), 8'h77);
`endif

        cyc(1, 16'h0011, 8'hFF, 4'd4, 4'd0, "bad1");
        chk("bad1.err_lit", int'(sel_err), 1);
        chk("bad1.cnt_lit", int'(err_cnt), 1);
        chk("bad1.done_lit", int'(wr_done), 0);
        cyc(0, 16'h0000, 8'h00, 4'd4, 4'd3, "bad1rd");
        chk("bad1rd.ra_lit", int'(ra_data), 8'h00);
        chk("bad1rd.rb_lit", int'(rb_data), 8'hA5);
        cyc(1, 16'h0000, 8'hEE, 4'd0, 4'd0, "bad0");
        chk("bad0.cnt_lit", int'(err_cnt), 2);
        cyc(0, 16'h0003, 8'hEE, 4'd0, 4'd1, "we0");
        chk("we0.cnt_lit", int'(err_cnt), 2);

        for (int n = 0; n < 20; n++) begin
            s = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            if ($countones(s) == 1) s = 16'hFFFF;
            cyc(1, s, 8'($urandom), 4'($urandom), 4'($urandom), "sat");
        end
        chk("sat.cnt_lit", int'(err_cnt), 15);
        cyc(0, 16'h0000, 8'h00, 4'd3, 4'd7, "sathold");
        chk("sathold.cnt_lit", int'(err_cnt), 15);

        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async.ra_lit", int'(ra_data), 0);
        chk("async.rb_lit", int'(rb_data), 0);
        chk("async.err_lit", int'(sel_err), 0);
        chk("async.cnt_lit", int'(err_cnt), 0);
        chk("async.done_lit", int'(wr_done), 0);
        @(negedge clk);
        check_all("async_hold");
        rst_n = 1'b1;
        cyc(0, 16'h0000, 8'h00, 4'd3, 4'd7, "post_rst");

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: s = 16'h0000;
                1, 2: s = 16'($urandom);
                default: s = 16'(1 << $urandom_range(0, 15));
            endcase
            cyc(1'($urandom_range(0, 3) != 0), s, 8'($urandom),
                4'($urandom), 4'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile16_onehot_wr.md
Name: regfile16_onehot_wr

Overview:
- 16-entry register file sitting directly downstream of the 4-to-16 address decoder.
- Writes are selected by the decoder's 16-bit one-hot output; reads use two independent 4-bit addresses.
- Read data is registered. Same-cycle writes are forwarded to the reads (write-first).
- Malformed write selects are rejected and flagged; this gives the CPU datapath a checked register bank.

Parameters:
- WIDTH, 8, data width of each register and of the read/write data buses.
- ERRW, 4, width of the saturating bad-select counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion clears state immediately; deassertion is sampled on the next clk rising edge.
- we  input  1  write request qualifier.
- wsel  input  16  one-hot write select, driven from the decoder outputs D[15:0].
- wdata  input  WIDTH  write data.
- ra_addr  input  4  read port A address.
- rb_addr  input  4  read port B address.
- ra_data  output  WIDTH  registered read data, port A.
- rb_data  output  WIDTH  registered read data, port B.
- wr_done  output  1  one-cycle pulse: a valid write was committed on the previous edge.
- sel_err  output  1  sticky flag: a write with an invalid wsel was seen.
- err_cnt  output  ERRW  saturating count of rejected writes.

Behaviour:
- Reset (rst_n low, asynchronous): all 16 registers = 0, ra_data = rb_data = 0, wr_done = 0, sel_err = 0, err_cnt = 0. Outputs hold these values while rst_n is low.
- Valid write: we=1 and wsel has exactly one bit set (popcount == 1).
  - On the edge, reg[i] <= wdata, where i is the index of the set bit.
  - wr_done = 1 for the following cycle, 0 otherwise.
- Invalid write: we=1 and popcount(wsel) is 0 or ≥2.
  - No register changes.
  - sel_err <= 1; it stays set until reset.
  - err_cnt <= err_cnt + 1, saturating at 2^ERRW−1 with no wrap.
  - wr_done = 0.
- we=0: wsel is ignored entirely, whatever its value. No write, no error, no count.
- Read timing: 1-cycle latency. ra_data at cycle n+1 = reg[ra_addr sampled at edge n], and likewise for port B.
- Write-first forwarding: if a valid write to index i occurs at the same edge and the read address equals i, the read output = wdata, not the old value. Applies independently to both ports.
  - Both ports reading the written index both get wdata.
- Invalid writes never forward.
- Read addresses are always in range (4 bits → 0..15); no out-of-range case.
- Reset mid-write: asynchronous reset wins. A write coincident with rst_n low is discarded.
- Internal one-hot check: a popcount/priority structure over wsel is permitted. The decoded index must equal the single set bit position.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- When defined:
  - Register 0 is hardwired to 0.
  - A valid write with wsel = 16'h0001 is accepted: wr_done pulses, sel_err and err_cnt are unaffected, but storage is not modified.
  - Reads of address 0 return 0, including when forwarding would apply.
- When undefined: register 0 is an ordinary storage register.

Test Plan:
- Reset then read: WIDTH=8. Release rst_n, read ra_addr=5, rb_addr=15 → next cycle ra_data=0x00, rb_data=0x00, sel_err=0, err_cnt=0.
- Write/readback:
  - we=1, wsel=16'h0008, wdata=0xA5 → wr_done=1 next cycle.
  - Then ra_addr=3 → ra_data=0xA5.
  - rb_addr=2 → rb_data=0x00.
- Forwarding: reg7 holds 0x11. Same edge: we=1, wsel=16'h0080, wdata=0x3C, ra_addr=7, rb_addr=7 → next cycle ra_data=rb_data=0x3C.
- Bad select:
  - we=1, wsel=16'h0011, wdata=0xFF → no register changes, sel_err=1, err_cnt=1, wr_done=0.
  - Then we=1, wsel=0 → err_cnt=2.
  - Then we=0, wsel=16'h0003 → err_cnt stays 2.
- Saturation and reset: 20 consecutive invalid writes with ERRW=4 → err_cnt=15 and holds. Assert rst_n low mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
- REGFILE_R0_ZERO_EN defined: we=1, wsel=16'h0001, wdata=0x77 with ra_addr=0 → wr_done=1, ra_data=0x00, then still 0x00 on re-read. Undefined build → ra_data=0x77.
